// File: rtl/rndn_axil_arbiter.sv
// rndn_axil_arbiter: round-robin arbiter that serializes two requesters onto one AXI4-Lite master,
// one transaction at a time, returning a one-cycle completion pulse to the served requester.
module rndn_axil_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [1:0]          rq_we,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_wdata,
  output logic [1:0]          rs_valid,
  output logic [DATA_W-1:0]   rs_rdata,
  output logic [1:0]          rs_resp,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  localparam logic [2:0] IDLE = 3'd0, WR_ADDR = 3'd1, WR_RESP = 3'd2, RD_ADDR = 3'd3, RD_RESP = 3'd4, DONE = 3'd5;
  logic [2:0] state, state_nx;
  logic last_grant, sel, idx, accept, aw_pend, w_pend, aw_hs, w_hs;
  logic [ADDR_W-1:0] addr, addr_sel;
  logic [DATA_W-1:0] wdata;
  // requester 1 wins when alone, or on a tie when requester 0 was served last
  assign sel = rq_valid[1] & (~rq_valid[0] | ~last_grant);
  assign accept = ARESETN && state == IDLE && |rq_valid;
  assign rq_ready = accept ? {sel, ~sel} : 2'b00;
  assign addr_sel = sel ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs = M_AXI_WVALID & M_AXI_WREADY;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA = wdata;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_AWVALID = aw_pend;
  assign M_AXI_WVALID = w_pend;
  assign M_AXI_BREADY = state == WR_RESP;
  assign M_AXI_ARVALID = state == RD_ADDR;
  assign M_AXI_RREADY = state == RD_RESP;
  assign rs_valid = state == DONE ? (idx ? 2'b10 : 2'b01) : 2'b00;
  always_comb
    state_nx = accept ? (rq_we[sel] ? WR_ADDR : RD_ADDR)
      : (state == WR_ADDR && (aw_hs || !aw_pend) && (w_hs || !w_pend)) ? WR_RESP
      : ((M_AXI_BREADY && M_AXI_BVALID) || (M_AXI_RREADY && M_AXI_RVALID)) ? DONE
      : (M_AXI_ARVALID && M_AXI_ARREADY) ? RD_RESP
      : state == DONE ? IDLE : state;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      last_grant <= 1'b1;
      idx <= 1'b0;
      addr <= '0;
      wdata <= '0;
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      rs_rdata <= '0;
      rs_resp <= 2'b00;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= sel;
        idx <= sel;
        addr <= addr_sel & ~ADDR_W'(3);
        wdata <= sel ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
        aw_pend <= rq_we[sel];
        w_pend <= rq_we[sel];
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs) w_pend <= 1'b0;
      if (M_AXI_BREADY && M_AXI_BVALID) rs_resp <= M_AXI_BRESP;
      if (M_AXI_RREADY && M_AXI_RVALID) begin
        rs_rdata <= M_AXI_RDATA;
        rs_resp <= M_AXI_RRESP;
      end
    end
endmodule

// File: tb/tb_rndn_axil_arbiter.sv
// tb_rndn_axil_arbiter: requester driver, reference memory and scoreboard around a delay-configurable
// AXI4-Lite slave model with protocol checks.
module tb_rndn_axil_arbiter;
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic [1:0] rq_valid = '0, rq_ready, rq_we = '0, rs_valid, rs_resp;
  logic [7:0] rq_addr = '0;
  logic [63:0] rq_wdata = '0;
  logic [31:0] rs_rdata, M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;

  rndn_axil_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rs_valid(rs_valid), .rs_rdata(rs_rdata), .rs_resp(rs_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic we; logic [3:0] addr; logic [31:0] data; } req_t;
  typedef struct { bit idx; logic [1:0] resp; logic [31:0] rdata; int acc; int lat; } exp_t;
  req_t q0[$], q1[$];
  req_t cur[2];
  exp_t sb[$];
  int grants[$];
  bit [1:0] busy = '0;
  bit tb_last = 1'b1;
  logic [31:0] ref_mem[4] = '{default: '0}, s_mem[4] = '{default: '0}, last_rd = '0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;

  task automatic push(int i, logic we, logic [3:0] a, logic [31:0] d);
    if (i == 0) q0.push_back({we, a, d});
    else q1.push_back({we, a, d});
  endtask

  // requester driver: keeps each requester's head request valid until granted, then predicts its result
  initial forever begin
    exp_t e;
    logic [1:0] exp_g;
    bit g;
    @(negedge ACLK);
    if (!ARESETN) begin
      tb_last = 1'b1;
      last_rd = '0;
    end
    if (!busy[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); busy[0] = 1'b1; end
    if (!busy[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); busy[1] = 1'b1; end
    rq_valid = busy;
    rq_we = {cur[1].we, cur[0].we};
    rq_addr = {cur[1].addr, cur[0].addr};
    rq_wdata = {cur[1].data, cur[0].data};
    #1;
    if (rq_ready != 2'b00) begin
      exp_g = (busy == 2'b11) ? (tb_last ? 2'b01 : 2'b10) : {busy[1], ~busy[1]};
      check("grant", rq_ready, exp_g);
      g = rq_ready[1];
      tb_last = g;
      grants.push_back(int'(g));
      busy[g] = 1'b0;
      e.idx = g;
      e.acc = cyc;
      if (cur[g].we) begin
        ref_mem[cur[g].addr[3:2]] = cur[g].data;
        e.resp = b_resp_cfg;
        e.rdata = last_rd;
        e.lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      end else begin
        last_rd = ref_mem[cur[g].addr[3:2]];
        e.resp = r_resp_cfg;
        e.rdata = last_rd;
        e.lat = 3 + ar_dly + r_dly;
      end
      sb.push_back(e);
    end
  end

  // completion monitor
  initial forever begin
    exp_t e;
    @(negedge ACLK);
    #2;
    if (rs_valid != 2'b00) begin
      if (sb.size() == 0) check("unexpected_rs_valid", rs_valid, 2'b00);
      else begin
        e = sb.pop_front();
        check("rs_valid", rs_valid, e.idx ? 2'b10 : 2'b01);
        check("rs_resp", rs_resp, e.resp);
        check("rs_rdata", rs_rdata, e.rdata);
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  // AXI4-Lite slave model; handshakes decided at a negedge complete at the following posedge
  bit aw_got, w_got, ar_got, b_hs, r_hs, aw_wait, w_wait, ar_wait;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [3:0] aw_seen, ar_seen, s_awaddr, s_araddr, s_wstrb;
  logic [31:0] w_seen, s_wdata;
  logic [2:0] s_awprot, s_arprot;
  initial begin
    {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
    M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
        {aw_got, w_got, ar_got, b_hs, r_hs, aw_wait, w_wait, ar_wait} = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_got) check("awvalid_after_hs", M_AXI_AWVALID, 1'b0);
        if (w_got) check("wvalid_after_hs", M_AXI_WVALID, 1'b0);
        if (ar_got) check("arvalid_after_hs", M_AXI_ARVALID, 1'b0);
        if (aw_wait) check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_seen});
        if (w_wait) check("w_hold", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, w_seen});
        if (ar_wait) check("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, ar_seen});
        if (M_AXI_AWVALID || M_AXI_WVALID) check("bready_early", M_AXI_BREADY, 1'b0);
        if (b_hs) begin
          M_AXI_BVALID = 1'b0; b_hs = 0; aw_got = 0; w_got = 0; b_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else if (aw_got && w_got) begin
          if (b_cnt == 0) s_mem[s_awaddr[3:2]] = s_wdata;
          if (b_cnt >= b_dly) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_resp_cfg; end
          b_cnt++;
          b_hs = M_AXI_BVALID && M_AXI_BREADY;
        end
        if (r_hs) begin
          M_AXI_RVALID = 1'b0; r_hs = 0; ar_got = 0; r_cnt = 0; ar_cnt = 0;
        end else if (ar_got) begin
          if (r_cnt >= r_dly) begin M_AXI_RVALID = 1'b1; M_AXI_RDATA = s_mem[s_araddr[3:2]]; M_AXI_RRESP = r_resp_cfg; end
          r_cnt++;
          r_hs = M_AXI_RVALID && M_AXI_RREADY;
        end
        if (!aw_got && M_AXI_AWVALID) begin
          M_AXI_AWREADY = aw_cnt >= aw_dly; aw_cnt++; aw_seen = M_AXI_AWADDR;
          if (M_AXI_AWREADY) begin aw_got = 1; s_awaddr = M_AXI_AWADDR; s_awprot = M_AXI_AWPROT; end
        end else M_AXI_AWREADY = 1'b0;
        if (!w_got && M_AXI_WVALID) begin
          M_AXI_WREADY = w_cnt >= w_dly; w_cnt++; w_seen = M_AXI_WDATA;
          if (M_AXI_WREADY) begin w_got = 1; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; end
        end else M_AXI_WREADY = 1'b0;
        if (!ar_got && M_AXI_ARVALID) begin
          M_AXI_ARREADY = ar_cnt >= ar_dly; ar_cnt++; ar_seen = M_AXI_ARADDR;
          if (M_AXI_ARREADY) begin ar_got = 1; s_araddr = M_AXI_ARADDR; s_arprot = M_AXI_ARPROT; end
        end else M_AXI_ARREADY = 1'b0;
        aw_wait = M_AXI_AWVALID && !aw_got;
        w_wait = M_AXI_WVALID && !w_got;
        ar_wait = M_AXI_ARVALID && !ar_got;
      end
    end
  end

  task automatic wait_idle(int bound);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy != 2'b00 || sb.size() > 0) && n < bound) begin
      @(negedge ACLK);
      n++;
    end
    check("timeout_pending", sb.size() + q0.size() + q1.size(), 0);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic check_reset_outputs(string tag);
    check(tag, {rq_ready, rs_valid, rs_rdata, rs_resp, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWADDR}, '0);
    check({tag, "_wdata"}, M_AXI_WDATA, '0);
  endtask

  initial begin
    int n;
    // both requesters pending from reset: writes from 0, reads from 1, interleaved
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b1, 4'h0, 32'hA + k);
      push(1, 1'b0, 4'h0, 32'h0);
    end
    repeat (3) @(negedge ACLK);
    #3 check_reset_outputs("reset_state");
    @(negedge ACLK);
    ARESETN = 1'b1;
    wait_idle(200);
    check("grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) check("grant_order", grants[i], i % 2);

    push(0, 1'b1, 4'h4, 32'h2);
    wait_idle(50);
    check("awaddr", s_awaddr, 4'h4);
    check("wdata", s_wdata, 32'h2);
    check("wstrb", s_wstrb, 4'hF);
    check("awprot", s_awprot, 3'b000);
    push(1, 1'b1, 4'h7, 32'h55);
    wait_idle(50);
    check("awaddr_aligned", s_awaddr, 4'h4);

    aw_dly = 0; w_dly = 3;
    push(0, 1'b1, 4'h8, 32'h3);
    wait_idle(50);
    w_dly = 0;

    r_dly = 4;
    push(1, 1'b0, 4'h8, 32'h0);
    wait_idle(50);
    check("araddr", s_araddr, 4'h8);
    check("arprot", s_arprot, 3'b000);
    r_dly = 0;

    // reset while waiting for the write response
    b_dly = 20;
    push(0, 1'b1, 4'hC, 32'hDEAD);
    n = 0;
    while (!M_AXI_BREADY && n < 100) begin @(negedge ACLK); n++; end
    check("reach_wr_resp", M_AXI_BREADY, 1'b1);
    #3 ARESETN = 1'b0;
    #1 check_reset_outputs("async_reset");
    sb.delete();
    grants.delete();
    b_dly = 0;
    push(0, 1'b0, 4'h0, 32'h0);
    push(1, 1'b0, 4'h4, 32'h0);
    repeat (3) @(negedge ACLK);
    #3 check_reset_outputs("held_reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    wait_idle(100);
    check("first_grant_after_reset", grants.size() > 0 ? grants[0] : -1, 0);

    aw_dly = 1; b_dly = 2; ar_dly = 2; r_dly = 1;
    for (int k = 0; k < 4; k++) push(k % 2, 1'b1, 4'(k * 4), 32'(k + 1));
    for (int k = 0; k < 4; k++) push(k % 2, 1'b0, 4'(k * 4), 32'h0);
    wait_idle(300);
    check("readback_last", last_rd, 32'h4);

    aw_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    b_resp_cfg = 2'b10;
    push(0, 1'b1, 4'h0, 32'h77);
    wait_idle(50);
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11;
    push(1, 1'b0, 4'h0, 32'h0);
    wait_idle(50);
    r_resp_cfg = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
